// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        MULT = 1'b0,
        DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Signed correction of the unsigned product / quotient / remainder into HI/LO.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the sequencer in its FIX cycle.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quo_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    input  op_e                op_i,
    output logic [WIDTH-1:0]   hi_next,
    output logic [WIDTH-1:0]   lo_next
);

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Product and quotient take the XOR of the operand signs; the remainder
    // follows the dividend so that a == q*b + r holds in two's complement.
    assign prod_fix = (sign_a_i ^ sign_b_i) ? -prod_i : prod_i;
    assign quo_fix  = (sign_a_i ^ sign_b_i) ? -quo_i  : quo_i;
    assign rem_fix  = sign_a_i ? -rem_i : rem_i;

    // Route the corrected value for the active operation onto HI/LO.
    always_comb begin
        hi_next = '0;
        lo_next = '0;
        if (op_i == MULT) begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
        end else begin
            hi_next = rem_fix;
            lo_next = quo_fix;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit with HI/LO.
// Latency: ITER+2 cycles start-to-done; divide-by-zero completes in 1 cycle.
// Backpressure: starts are only sampled in IDLE; anything arriving while busy is dropped.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    state_e             state_q,  state_d;
    op_e                op_q,     op_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    // Multiplicand magnitude for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    // MULT: {partial product, remaining multiplier bits}.
    // DIV:  low half holds dividend bits shifting out and quotient bits shifting in.
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH:0]     rem_q,    rem_d;
    logic               div0_q,   div0_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               q_bit;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

    // One multiplier bit per cycle: conditionally add, then shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // The extra top bit gives the borrow that decides the quotient bit.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {2'b00, mcand_q};
    assign q_bit     = ~div_trial[WIDTH+1];

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .prod_i   (acc_q),
        .quo_i    (acc_q[WIDTH-1:0]),
        .rem_i    (rem_q[WIDTH-1:0]),
        .sign_a_i (sign_a_q),
        .sign_b_i (sign_b_q),
        .op_i     (op_q),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // State sequencing and datapath next-state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        div0_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    op_d     = MULT;
                    sign_a_d = op_a[WIDTH-1];
                    sign_b_d = op_b[WIDTH-1];
                    mcand_d  = a_mag;
                    acc_d    = {{WIDTH{1'b0}}, b_mag};
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else if (start_div) begin
                    if (op_b == '0) begin
                        // Flag only; HI/LO keep the previous result.
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        op_d     = DIV;
                        sign_a_d = op_a[WIDTH-1];
                        sign_b_d = op_b[WIDTH-1];
                        mcand_d  = b_mag;
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        rem_d    = '0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (op_q == MULT) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    rem_d = q_bit ? div_trial[WIDTH:0] : div_shift[WIDTH:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = hi_next;
                lo_d    = lo_next;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= MULT;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    localparam int W    = 32;
    localparam int ITER = W;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
        int           lat;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         start_mult;
    logic         start_div;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t         sb_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mdu_sequencer #(
        .WIDTH (W),
        .ITER  (ITER)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div0       (div0),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: signed arithmetic in 64 bits, truncated to HI/LO.
    task automatic push_expected(input logic sm, input logic sd,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.div0 = 1'b0;
        e.lat  = ITER + 2;
        if (sm) begin
            p    = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (sd && b == '0) begin
            e.div0 = 1'b1;
            e.lat  = 1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb_q.push_back(e);
    endtask

    // Launch one operation and compare against the scoreboard at done.
    // inject: cycle index at which a stray start_div is pulsed (-1 for none).
    // poke_done: drive a start_mult during the DONE cycle, which must be ignored.
    task automatic run_op(input string tag, input logic sm, input logic sd,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject, input bit poke_done);
        exp_t e;
        int   cyc;
        bit   got;
        push_expected(sm, sd, a, b);
        start_mult = sm;
        start_div  = sd;
        op_a       = a;
        op_b       = b;
        @(posedge clock); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc <= 100) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (inject >= 0 && cyc == inject + 1) begin
                check({tag, "_busy_ign"}, 64'(busy), 64'd1);
            end
            start_div = (cyc == inject);
            @(posedge clock); #1;
            cyc++;
        end
        start_div = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_hi"},   64'(hi),   64'(e.hi));
            check({tag, "_lo"},   64'(lo),   64'(e.lo));
            check({tag, "_div0"}, 64'(div0), 64'(e.div0));
            check({tag, "_lat"},  64'(cyc),  64'(e.lat));
            check({tag, "_busy_done"}, 64'(busy), 64'd1);
        end
        if (poke_done) begin
            start_mult = 1'b1;
            op_a       = 32'd2;
            op_b       = 32'd2;
        end
        @(posedge clock); #1;
        start_mult = 1'b0;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_div0_drop"}, 64'(div0), 64'd0);
        check({tag, "_idle"},      64'(busy), 64'd0);
        check({tag, "_hold_hi"},   64'(hi),   64'(m_hi));
        check({tag, "_hold_lo"},   64'(lo),   64'(m_lo));
    endtask

    initial begin
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul_7x-3",   1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, -1, 1'b0);
        run_op("div_-7/2",   1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        -1, 1'b1);
        run_op("div_min/-1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        run_op("div_prime",  1'b0, 1'b1, 32'h56781234, 32'h00010000, -1, 1'b0);
        run_op("div_5/0",    1'b0, 1'b1, 32'd5,        32'd0,        -1, 1'b0);
        run_op("both_3x4",   1'b1, 1'b1, 32'd3,        32'd4,        10, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         is_mul;
            ra     = $urandom;
            rb     = $urandom;
            is_mul = 1'($urandom_range(0, 1));
            if (!is_mul && rb == '0) rb = 32'd1;
            run_op($sformatf("rnd%0d", i), is_mul, !is_mul, ra, rb, -1, 1'b0);
        end

        // Reset in the middle of RUN abandons the operation.
        start_mult = 1'b1;
        op_a       = 32'd9;
        op_b       = 32'd9;
        @(posedge clock); #1;
        start_mult = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi",   64'(hi),   64'd0);
        check("midrst_lo",   64'(lo),   64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        run_op("mul_m1xm1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and HI/LO width.
REQ-002 The block SHALL have parameter ITER, default WIDTH, giving the iteration cycles per operation.
REQ-003 The block SHALL have port clock  input  1  rising-edge system clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start_mult  input  1  request signed multiply, sampled in IDLE only.
REQ-006 The block SHALL have port start_div  input  1  request signed divide, sampled in IDLE only.
REQ-007 The block SHALL have port op_a  input  WIDTH  multiplicand/dividend (rs), sampled with start.
REQ-008 The block SHALL have port op_b  input  WIDTH  multiplier/divisor (rt), sampled with start.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when HI/LO hold a new result or div0 is flagged.
REQ-011 The block SHALL have port div0  output  1  divide-by-zero flag, valid with done.
REQ-012 The block SHALL have port hi  output  WIDTH  HI register.
REQ-013 The block SHALL have port lo  output  WIDTH  LO register.

Function
REQ-014 States SHALL be IDLE, RUN, FIX, DONE; the state register SHALL be updated on the rising edge of clock.
REQ-015 In IDLE, start_mult=1 SHALL latch op_a/op_b magnitudes and sign bits, set op=MULT, and go to RUN.
REQ-016 In IDLE, start_div=1 with op_b!=0 SHALL latch op_a/op_b magnitudes and sign bits, set op=DIV, and go to RUN.
REQ-017 In IDLE, start_div=1 with op_b==0 SHALL go directly to DONE with div0=1 and hi/lo unchanged.
REQ-018 If start_mult and start_div are both 1, multiply SHALL win and the divide SHALL be dropped.
REQ-019 Starts asserted while busy=1 SHALL be ignored without queuing.
REQ-020 RUN SHALL last exactly ITER cycles, counted by an iteration counter cleared on entry; the last count SHALL transition to FIX.
REQ-021 MULT in RUN: unsigned shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
REQ-022 DIV in RUN: unsigned restoring division, one quotient bit per cycle; the partial remainder SHALL be WIDTH+1 bits.
REQ-023 FIX (1 cycle): MULT SHALL negate the 2*WIDTH product if sign_a^sign_b, then write hi=upper and lo=lower half.
REQ-024 FIX for DIV SHALL set lo=quotient, negated if sign_a^sign_b, and hi=remainder, negated if sign_a.
REQ-025 The INT_MIN / -1 divide SHALL wrap: lo=0x80000000, hi=0, div0=0.
REQ-026 DONE SHALL last 1 cycle with done=1, then return to IDLE; a start in that DONE cycle SHALL be ignored.
REQ-027 Total latency SHALL be ITER+2 cycles from the start-sampling edge to the done cycle (34 for WIDTH=32), and 1 cycle for div0.
REQ-028 hi/lo SHALL change only in FIX and SHALL hold otherwise, including across a div0 operation.
REQ-029 div0 SHALL be 0 except in the DONE cycle of a divide-by-zero operation.

Reset
REQ-030 reset=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, div0=0, hi=0, lo=0, and clear all operand, sign and accumulator registers.
REQ-031 Reset asserted mid-RUN or mid-FIX SHALL abandon the operation with no partial hi/lo update.
REQ-032 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package mdu_pkg SHALL hold: WIDTH default constant, state enum (IDLE/RUN/FIX/DONE), op enum (MULT/DIV).
REQ-034 Sign correction SHALL be one combinational sub-module, mdu_sign_fix (inputs: raw product/quotient/remainder, signs, op; outputs: hi_next, lo_next).
REQ-035 The iteration datapath and FSM SHALL reside in mdu_sequencer; no other sub-modules.

Verification
REQ-036 mult 7 x -3 (0xFFFFFFFD) -> done 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div0=0.
REQ-037 div -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 prior hi=0x1234, lo=0x5678; div 5 / 0 -> done+div0 on next cycle, hi=0x1234, lo=0x5678 unchanged.
REQ-039 start_mult and start_div together, a=3, b=4 -> multiply result hi=0, lo=12; start_div pulsed at cycle 10 of RUN -> ignored, busy stays 1.
REQ-040 reset low at RUN cycle 15 -> busy=0, hi=lo=0 immediately; new mult 0xFFFFFFFF x 0xFFFFFFFF after release -> hi=0, lo=1.
